// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, maximal-length LFSR tap masks for 4..16 bits,
// a width-aware rotate-left and the seed sanitiser shared by all SC blocks.
package sc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MAX_W = 16;

    // Fibonacci feedback taps: bit (t-1) set for every polynomial term x^t.
    function automatic logic [15:0] lfsr_taps(input int w);
        case (w)
            4:       return 16'h000C;  // x^4+x^3+1
            5:       return 16'h0014;  // x^5+x^3+1
            6:       return 16'h0030;  // x^6+x^5+1
            7:       return 16'h0060;  // x^7+x^6+1
            8:       return 16'h00B8;  // x^8+x^6+x^5+x^4+1
            9:       return 16'h0110;  // x^9+x^5+1
            10:      return 16'h0240;  // x^10+x^7+1
            11:      return 16'h0500;  // x^11+x^9+1
            12:      return 16'h0829;  // x^12+x^6+x^4+x+1
            13:      return 16'h100D;  // x^13+x^4+x^3+x+1
            14:      return 16'h2015;  // x^14+x^5+x^3+x+1
            15:      return 16'h6000;  // x^15+x^14+1
            16:      return 16'hD008;  // x^16+x^15+x^13+x^4+1
            default: return 16'h00B8;
        endcase
    endfunction

    function automatic logic [15:0] width_mask(input int w);
        // w==16 shifts the one out, and 0-1 wraps to all ones.
        return (16'd1 << w) - 16'd1;
    endfunction

    // Rotate the low w bits of value left by amount; bits above w stay zero.
    function automatic logic [15:0] rotl(input logic [15:0] value, input int amount, input int w);
        logic [15:0] res;
        logic [3:0]  pos;
        res = '0;
        for (int b = 0; b < MAX_W; b++) begin
            if (b < w) begin
                pos      = 4'((b + amount) % w);
                res[pos] = value[b];
            end
        end
        return res;
    endfunction

    // An all-zero LFSR would lock up, so a zero seed becomes 1.
    function automatic logic [15:0] seed_value(input int seed, input int w);
        logic [15:0] s;
        s = 16'(seed) & width_mask(w);
        return (s == 16'd0) ? 16'd1 : s;
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Maximal-length W-bit Fibonacci LFSR, never zero, reloadable to SEED.
// Latency: q updates on the clock edge following load/step.
// Backpressure: holds its state whenever step is low.
// Ports: clk, reset (async active-low), load (reload SEED, wins over step),
// step (advance one state), q (current state).
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int W    = 8,
    parameter int SEED = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    output logic [W-1:0] q
);

    localparam logic [15:0]  SEED16 = seed_value(SEED, W);
    localparam logic [W-1:0] SEED_W = SEED16[W-1:0];
    localparam logic [15:0]  TAPS16 = lfsr_taps(W);
    localparam logic [W-1:0] TAPS   = TAPS16[W-1:0];

    logic [W-1:0] q_next;

    assign q_next = {q[W-2:0], ^(q & TAPS)};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= SEED_W;
        end else if (load) begin
            q <= SEED_W;
        end else if (step) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/sc_sng_array.sv
// N-lane binary-to-stochastic encoder: one LFSR period of bits per captured word.
// Latency: first beat registered 1 cycle after load; one beat per accepted transfer.
// Backpressure: out_ready low freezes stream_out/stream_last/LFSR/counter; loads only in IDLE.
// Ports: clk, reset (async active-low), val_in/load_valid/load_ready (word load),
// stream_out/stream_valid/out_ready/stream_last (beat stream), done, busy.
module sc_sng_array
    import sc_pkg::*;
#(
    parameter int K    = 3,
    parameter int N    = 2**K,
    parameter int W    = 8,
    parameter int L    = 2**W - 1,
    parameter int SEED = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N*W-1:0] val_in,
    input  logic           load_valid,
    output logic           load_ready,
    output logic [N-1:0]   stream_out,
    output logic           stream_valid,
    input  logic           out_ready,
    output logic           stream_last,
    output logic           done,
    output logic           busy
);

    localparam int            CW       = $clog2(L + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(L - 1);
    localparam logic [CW-1:0] CNT_PEN  = CW'(L - 2);
    localparam logic [15:0]   SEED16   = seed_value(SEED, W);
    localparam logic [W-1:0]  SEED_W   = SEED16[W-1:0];
    localparam logic [15:0]   TAPS16   = lfsr_taps(W);
    localparam logic [W-1:0]  TAPS     = TAPS16[W-1:0];

    state_t         state;
    state_t         state_nxt;
    logic [N*W-1:0] vals;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   lfsr_q;
    logic [W-1:0]   lfsr_ahead;
    logic           load_fire;
    logic           beat_fire;
    logic           last_fire;
    logic [N*W-1:0] cmp_vals;
    logic [W-1:0]   cmp_rand;
    logic [15:0]    rand16;
    logic [N-1:0]   bits_nxt;

    sc_lfsr #(
        .W    (W),
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (load_fire),
        .step  (beat_fire),
        .q     (lfsr_q)
    );

    // stream_out is registered, so the beat after a transfer is built from the
    // LFSR state one step ahead of the one currently held in u_lfsr.
    assign lfsr_ahead = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};

    // At load time the first beat uses the incoming words and the seed itself.
    assign cmp_vals = load_fire ? val_in : vals;
    assign cmp_rand = load_fire ? SEED_W : lfsr_ahead;

    always_comb begin
        rand16             = '0;
        rand16[W-1:0]      = cmp_rand;
    end

    // Each lane sees its own rotation of the shared LFSR word; a rotation of a
    // full nonzero period visits 1..L once, so exactly v draws satisfy r <= v.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [15:0] r16;
        logic [15:0] v16;
        assign r16         = rotl(rand16, (3 * i) % W, W);
        assign v16         = {{(16 - W){1'b0}}, cmp_vals[i*W +: W]};
        assign bits_nxt[i] = (r16 <= v16);
    end

    always_comb begin
        state_nxt = state;
        load_fire = 1'b0;
        beat_fire = 1'b0;
        last_fire = 1'b0;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    load_fire = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (out_ready) begin
                    beat_fire = 1'b1;
                    if (cnt == CNT_LAST) begin
                        last_fire = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vals        <= '0;
            cnt         <= '0;
            stream_out  <= '0;
            stream_last <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= last_fire;
            if (load_fire) begin
                vals        <= val_in;
                cnt         <= '0;
                stream_out  <= bits_nxt;
                stream_last <= 1'b0;
            end else if (last_fire) begin
                cnt         <= cnt + CW'(1);
                stream_out  <= '0;
                stream_last <= 1'b0;
            end else if (beat_fire) begin
                cnt         <= cnt + CW'(1);
                stream_out  <= bits_nxt;
                stream_last <= (cnt == CNT_PEN);
            end
        end
    end

    assign stream_valid = (state == RUN);
    assign busy         = (state == RUN);
    // Gated by reset so load_ready reads 0 while reset is held.
    assign load_ready   = (state == IDLE) && reset;

endmodule

// File: tb/tb_sc_sng_array.sv
// Self-checking bench for sc_sng_array (K=3, W=8): a job-level reference model
// predicts handshake state and every beat; per-job counts and lane distinctness
// are checked against the captured words.
module tb_sc_sng_array;

    localparam int N = 8;
    localparam int W = 8;
    localparam int L = 255;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N*W-1:0] val_in = '0;
    logic           load_valid = 1'b0;
    logic           load_ready;
    logic [N-1:0]   stream_out;
    logic           stream_valid;
    logic           out_ready = 1'b0;
    logic           stream_last;
    logic           done;
    logic           busy;

    sc_sng_array #(.K(3), .W(W), .SEED(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .val_in       (val_in),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .stream_out   (stream_out),
        .stream_valid (stream_valid),
        .out_ready    (out_ready),
        .stream_last  (stream_last),
        .done         (done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] V2 = 64'h0000_0000_0001_80FF;
    localparam logic [63:0] V6 = 64'h8080_8080_8080_8080;

    // ---------------- reference model (arithmetic form of the encoding rules)
    function automatic int m_step(input int s);
        int fb;
        fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
        return ((s << 1) | fb) & 255;
    endfunction

    function automatic int m_rotl(input int s, input int a);
        return ((s << a) | (s >> (8 - a))) & 255;
    endfunction

    function automatic logic [7:0] m_beat(input logic [63:0] v, input int s);
        logic [7:0] b;
        int r;
        for (int i = 0; i < N; i++) begin
            r    = m_rotl(s, (3 * i) % 8);
            b[i] = (r <= int'(v[i*8 +: 8]));
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    logic [7:0]   exp_beat [L];
    logic [7:0]   rec      [L];
    logic [254:0] lane_seq [N];
    int           ones     [N];
    int           cap_v    [N];
    bit           m_idle = 1'b1;
    bit           m_done_exp = 1'b0;
    bit           prev_stall = 1'b0;
    logic [7:0]   prev_out = '0;
    int           idx = 0;
    int           jobs_started = 0;
    int           jobs_done = 0;
    int           cyc = 0;
    int           last_done_cyc = -100;
    int           last_gap = 0;
    bit           rec_en = 1'b0;
    bit           cmp_rec = 1'b0;

    task automatic model_capture(input logic [63:0] v);
        int s;
        s = 1;
        for (int k = 0; k < L; k++) begin
            exp_beat[k] = m_beat(v, s);
            s           = m_step(s);
        end
        for (int i = 0; i < N; i++) begin
            cap_v[i] = int'(v[i*8 +: 8]);
            ones[i]  = 0;
        end
        idx = 0;
    endtask

    task automatic job_end_checks();
        for (int i = 0; i < N; i++) chk($sformatf("ones_lane%0d", i), 64'(ones[i]), 64'(cap_v[i]));
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++)
                if (cap_v[i] == cap_v[j] && cap_v[i] != 0 && cap_v[i] != L)
                    chk($sformatf("lanes_%0d_%0d_identical", i, j), 64'(lane_seq[i] == lane_seq[j]), 64'd0);
    endtask

    // ---------------- compare process: sampled on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            chk("rst_stream_out", 64'(stream_out), 64'd0);
            chk("rst_stream_valid", 64'(stream_valid), 64'd0);
            chk("rst_stream_last", 64'(stream_last), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_load_ready", 64'(load_ready), 64'd0);
            m_idle     = 1'b1;
            m_done_exp = 1'b0;
            prev_stall = 1'b0;
            idx        = 0;
        end else begin
            chk("load_ready", 64'(load_ready), 64'(m_idle));
            chk("stream_valid", 64'(stream_valid), 64'(!m_idle));
            chk("busy", 64'(busy), 64'(!m_idle));
            chk("done", 64'(done), 64'(m_done_exp));
            if (m_done_exp) last_done_cyc = cyc;
            m_done_exp = 1'b0;
            if (!m_idle) begin
                chk("stream_out", 64'(stream_out), 64'(exp_beat[idx]));
                chk("stream_last", 64'(stream_last), 64'(idx == L - 1));
                if (prev_stall) chk("stall_hold", 64'(stream_out), 64'(prev_out));
                prev_out   = stream_out;
                prev_stall = !out_ready;
                if (out_ready) begin
                    if (cmp_rec) chk("vs_first_job", 64'(stream_out), 64'(rec[idx]));
                    if (rec_en) rec[idx] = stream_out;
                    for (int i = 0; i < N; i++) begin
                        ones[i]          += int'(stream_out[i]);
                        lane_seq[i][idx]  = stream_out[i];
                    end
                    idx++;
                    if (idx == L) begin
                        job_end_checks();
                        m_idle     = 1'b1;
                        m_done_exp = 1'b1;
                        jobs_done++;
                    end
                end
            end else begin
                chk("idle_last", 64'(stream_last), 64'd0);
                if (load_valid) begin
                    model_capture(val_in);
                    m_idle     = 1'b0;
                    prev_stall = 1'b0;
                    last_gap   = cyc + 1 - last_done_cyc;
                    jobs_started++;
                end
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic do_load(input logic [63:0] v);
        int target;
        int n;
        target = jobs_started + 1;
        n      = 0;
        @(posedge clk); #1;
        val_in     = v;
        load_valid = 1'b1;
        while (jobs_started < target && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        load_valid = 1'b0;
        if (jobs_started < target) begin
            checks++; errors++;
            $display("FAIL load_timeout: jobs_started %0d, required %0d", jobs_started, target);
        end
    endtask

    task automatic wait_done(input int target, input bit rnd);
        int n;
        n = 0;
        while (jobs_done < target && n < 4000) begin
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        out_ready = 1'b1;
        if (jobs_done < target) begin
            checks++; errors++;
            $display("FAIL done_timeout: jobs_done %0d, required %0d", jobs_done, target);
        end
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, cycles exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int target;
        int n;

        // Model pins: hand-derived LFSR states and first beats of the V2 job.
        s = 1;
        for (int k = 0; k < 5; k++) s = m_step(s);
        chk("model_lfsr_5steps", 64'(s), 64'd35);
        for (int k = 5; k < L; k++) s = m_step(s);
        chk("model_lfsr_period", 64'(s), 64'd1);
        chk("model_beat0", 64'(m_beat(V2, 1)), 64'h03);
        chk("model_beat2", 64'(m_beat(V2, 4)), 64'h07);
        chk("model_beat4", 64'(m_beat(V2, 17)), 64'h01);

        // 1: reset held for 3 cycles, then idle with no load
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (5) @(posedge clk);

        // 2: exact encoding, always ready
        out_ready = 1'b1;
        rec_en    = 1'b1;
        do_load(V2);
        wait_done(1, 1'b0);
        rec_en = 1'b0;
        chk("dut_beat0", 64'(rec[0]), 64'h03);
        chk("dut_beat2", 64'(rec[2]), 64'h07);
        chk("dut_beat4", 64'(rec[4]), 64'h01);

        // 3: same job under random backpressure
        cmp_rec = 1'b1;
        do_load(V2);
        wait_done(2, 1'b1);
        cmp_rec = 1'b0;

        // 4: load_valid held with changing words across two jobs
        target = jobs_started + 2;
        n      = 0;
        @(posedge clk); #1;
        load_valid = 1'b1;
        val_in     = {$urandom, $urandom};
        while (jobs_started < target && n < 2000) begin
            @(posedge clk); #1;
            val_in = {$urandom, $urandom};
            n++;
        end
        load_valid = 1'b0;
        wait_done(4, 1'b0);
        chk("back_to_back_gap", 64'(last_gap), 64'd2 - 64'd1);

        // 5: reset in the middle of a job, then reload the same words
        do_load(V2);
        n = 0;
        while (idx < 100 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #3 reset = 1'b0;
        #1;
        chk("async_stream_valid", 64'(stream_valid), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cmp_rec = 1'b1;
        do_load(V2);
        wait_done(5, 1'b0);
        cmp_rec = 1'b0;

        // 6: decorrelation, every lane at one half
        do_load(V6);
        wait_done(6, 1'b0);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
